// File: rtl/preg_free_list_ctrl_if.sv
// rtl/preg_free_list_ctrl_if.sv - rename/commit bus for the physical-register free list
// Purpose: bundles the alloc, release, checkpoint and status signals of the free list.
// Signals:
//   alloc_req_i / alloc_gnt_o / alloc_preg_o  : renamer allocation handshake
//   release_valid_i / release_preg_i          : in-order commit release
//   ckpt_take_i / br_valid_i / br_hit_i       : branch checkpoint and resolve
//   free_count_o / empty_o / err_o            : registered status
// Modports: master = rename/commit side, slave = free-list controller.
interface preg_free_list_ctrl_if #(
   parameter int PREG_W = 6,
   parameter int PTR_W  = 6
);
   logic              alloc_req_i;
   logic              alloc_gnt_o;
   logic [PREG_W-1:0] alloc_preg_o;
   logic              release_valid_i;
   logic [PREG_W-1:0] release_preg_i;
   logic              ckpt_take_i;
   logic              br_valid_i;
   logic              br_hit_i;
   logic [PTR_W-1:0]  free_count_o;
   logic              empty_o;
   logic              err_o;

   modport master (
      output alloc_req_i, release_valid_i, release_preg_i,
             ckpt_take_i, br_valid_i, br_hit_i,
      input  alloc_gnt_o, alloc_preg_o, free_count_o, empty_o, err_o
   );

   modport slave (
      input  alloc_req_i, release_valid_i, release_preg_i,
             ckpt_take_i, br_valid_i, br_hit_i,
      output alloc_gnt_o, alloc_preg_o, free_count_o, empty_o, err_o
   );
endinterface

// File: rtl/preg_free_list_ctrl.sv
// rtl/preg_free_list_ctrl.sv - circular-FIFO physical-register free list with branch checkpoint
// Purpose: grants one free preg per cycle (zero latency), accepts one committed release
//          per cycle, and restores the head pointer from a single checkpoint on mispredict.
// Ports:
//   clk   : clock
//   rst_i : synchronous active-high reset
//   bus   : preg_free_list_ctrl_if.slave (alloc, release, checkpoint, status)
module preg_free_list_ctrl #(
   parameter int NUM_PHYS_REGS = 64,
   parameter int NUM_ARCH_REGS = 32,
   parameter int PREG_W        = 6,
   parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
   parameter int PTR_W         = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_i,
   preg_free_list_ctrl_if.slave bus
);
   localparam int IDX_W = PTR_W - 1;

   logic [PREG_W-1:0] mem_q [DEPTH];
   logic [PREG_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W-1:0]  ckpt_head_q, ckpt_head_d;
   logic              ckpt_valid_q, ckpt_valid_d;
   logic [PTR_W-1:0]  count_q, count_d;
   logic              empty_q, empty_d;
   logic              err_q, err_d;

   logic              full;
   logic              flush;
   logic              gnt;
   logic              rel_ok;
   logic [PTR_W-1:0]  head_next;
   logic [PTR_W-1:0]  restore_count;

   // full/empty come from the registered count, so a release arriving while the pool
   // is empty cannot be bypassed to the renamer, and a full pool drops the release
   // even if a grant happens in the same cycle.
   assign full  = (count_q == PTR_W'(DEPTH));
   assign flush = bus.br_valid_i & ~bus.br_hit_i & ckpt_valid_q;
   assign gnt   = bus.alloc_req_i & ~empty_q & ~flush & ~rst_i;

   assign bus.alloc_gnt_o  = gnt;
   assign bus.alloc_preg_o = mem_q[head_q[IDX_W-1:0]];
   assign bus.free_count_o = count_q;
   assign bus.empty_o      = empty_q;
   assign bus.err_o        = err_q;

   always_comb begin
      mem_d         = mem_q;
      head_d        = head_q;
      tail_d        = tail_q;
      ckpt_head_d   = ckpt_head_q;
      ckpt_valid_d  = ckpt_valid_q;
      err_d         = err_q;
      restore_count = '0;

      head_next = head_q + PTR_W'(gnt);
      rel_ok    = bus.release_valid_i & (bus.release_preg_i != '0) & ~full;

      if (rel_ok) begin
         mem_d[tail_q[IDX_W-1:0]] = bus.release_preg_i;
         tail_d = tail_q + PTR_W'(1);
      end
      if (bus.release_valid_i && (bus.release_preg_i != '0) && full) begin
         err_d = 1'b1;
      end

      head_d = head_next;
      if (flush) begin
         head_d = ckpt_head_q;
         // A restore that would yield more than DEPTH free entries means the
         // checkpoint and the release stream disagree; flag it but still restore.
         restore_count = tail_d - ckpt_head_q;
         if (restore_count > PTR_W'(DEPTH)) begin
            err_d = 1'b1;
         end
      end

      // Any resolve against a live checkpoint consumes it; a take in the same cycle
      // as a resolve is ignored so the branch being resolved is never re-armed.
      if (bus.br_valid_i) begin
         ckpt_valid_d = 1'b0;
      end else if (bus.ckpt_take_i) begin
         ckpt_head_d  = head_next;
         ckpt_valid_d = 1'b1;
      end

      count_d = tail_d - head_d;
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= PREG_W'(NUM_ARCH_REGS + i);
         end
         head_q       <= '0;
         tail_q       <= PTR_W'(DEPTH);
         ckpt_head_q  <= '0;
         ckpt_valid_q <= 1'b0;
         count_q      <= PTR_W'(DEPTH);
         empty_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         ckpt_head_q  <= ckpt_head_d;
         ckpt_valid_q <= ckpt_valid_d;
         count_q      <= count_d;
         empty_q      <= empty_d;
         err_q        <= err_d;
      end
   end
endmodule
